// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC, keeps one imem request in flight,
// and fills the IF/ID register, handling redirects, stalls and flushes.
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   mux_to_pc          - next-PC select: 00/11 sequential, 01 branch, 10 jalr
//   IF_Flush, stall    - IF/ID flush and load-use hold
//   branch_target      - target used for mux_to_pc = 01
//   jalr_target        - target used for mux_to_pc = 10
//   imem_req_valid/ready, imem_addr         - fetch request channel
//   imem_resp_valid, imem_resp_data         - fetch response channel
//   IF_ID_pc, IF_ID_instr, IF_ID_valid      - IF/ID pipeline register
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mux_to_pc,
   input  logic        IF_Flush,
   input  logic        stall,
   input  logic [31:0] branch_target,
   input  logic [31:0] jalr_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] IF_ID_pc,
   output logic [31:0] IF_ID_instr,
   output logic        IF_ID_valid
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] pc_inc;
   logic [31:0] fetch_pc;
   logic [31:0] hold_word;
   logic [31:0] target;

   logic        redirect;
   logic        accept;
   logic        cap_fetch;
   logic        cap_hold;
   logic        ld_resp;
   logic        ld_hold;

   assign redirect = (mux_to_pc == 2'b01) || (mux_to_pc == 2'b10);
   assign target   = ((mux_to_pc == 2'b01) ? branch_target : jalr_target)
                     & 32'hFFFF_FFFC;
   assign accept   = imem_req_valid && imem_req_ready;
   // 32-bit add wraps naturally at the top of the address space
   assign pc_inc   = pc + 32'd4;

   // state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= S_REQ;
      else
         state <= state_nxt;
   end

   // next-state and datapath control
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      cap_fetch = 1'b0;
      cap_hold  = 1'b0;
      ld_resp   = 1'b0;
      ld_hold   = 1'b0;
      unique case (state)
         S_REQ: begin
            if (redirect) begin
               pc_nxt = target;
               // request already left for the old pc: its reply is stale
               if (accept)
                  state_nxt = S_DROP;
            end else if (accept) begin
               cap_fetch = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               state_nxt = S_REQ;
               if (redirect) begin
                  pc_nxt = target;
               end else begin
                  pc_nxt = pc_inc;
                  if (stall) begin
                     cap_hold  = 1'b1;
                     state_nxt = S_HOLD;
                  end else begin
                     ld_resp = 1'b1;
                  end
               end
            end else if (redirect) begin
               pc_nxt    = target;
               state_nxt = S_DROP;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_nxt    = target;
               state_nxt = S_REQ;
            end else if (!stall) begin
               ld_hold   = 1'b1;
               state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect)
               pc_nxt = target;
            if (imem_resp_valid)
               state_nxt = S_REQ;
         end
         default: begin
            state_nxt = S_REQ;
         end
      endcase
   end

   // outputs; no request is offered while reset is held
   always_comb begin
      imem_req_valid = (state == S_REQ) && !reset;
      imem_addr      = pc;
   end

   // pc, fetch address and hold buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_PC;
         fetch_pc  <= 32'h0;
         hold_word <= 32'h0;
      end else begin
         pc <= pc_nxt;
         if (cap_fetch)
            fetch_pc <= pc;
         if (cap_hold)
            hold_word <= imem_resp_data;
      end
   end

   // IF/ID register: flush > stall > load > bubble
   always_ff @(posedge clk) begin
      if (reset || IF_Flush) begin
         IF_ID_valid <= 1'b0;
         IF_ID_instr <= NOP_INSTR;
         IF_ID_pc    <= 32'h0;
      end else if (stall) begin
         IF_ID_valid <= IF_ID_valid;
      end else if (ld_resp) begin
         IF_ID_valid <= 1'b1;
         IF_ID_instr <= imem_resp_data;
         IF_ID_pc    <= fetch_pc;
      end else if (ld_hold) begin
         IF_ID_valid <= 1'b1;
         IF_ID_instr <= hold_word;
         IF_ID_pc    <= fetch_pc;
      end else begin
         IF_ID_valid <= 1'b0;
         IF_ID_instr <= NOP_INSTR;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, then randomized traffic
// checked against a queue-based model of the fetch behaviour.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mux_to_pc;
   logic        IF_Flush;
   logic        stall;
   logic [31:0] branch_target;
   logic [31:0] jalr_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic [31:0] IF_ID_pc;
   logic [31:0] IF_ID_instr;
   logic        IF_ID_valid;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .mux_to_pc       (mux_to_pc),
      .IF_Flush        (IF_Flush),
      .stall           (stall),
      .branch_target   (branch_target),
      .jalr_target     (jalr_target),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .IF_ID_pc        (IF_ID_pc),
      .IF_ID_instr     (IF_ID_instr),
      .IF_ID_valid     (IF_ID_valid)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] iw(input logic [31:0] a);
      return a ^ 32'hA5C3_0F1E;
   endfunction

   typedef struct {
      logic        rst;
      logic [1:0]  mux;
      logic        fl;
      logic        st;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic [31:0] bt;
      logic [31:0] jt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_pc;
      logic [31:0] e_in;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic [1:0] mux,
                      input logic fl, input logic st, input logic rdy,
                      input logic rv, input logic [31:0] rd,
                      input logic [31:0] bt, input logic [31:0] jt,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic e_v, input logic [31:0] e_pc,
                      input logic [31:0] e_in);
      vec_t v;
      v.rst = rst; v.mux = mux; v.fl = fl; v.st = st; v.rdy = rdy;
      v.rv = rv; v.rd = rd; v.bt = bt; v.jt = jt;
      v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v;
      v.e_pc = e_pc; v.e_in = e_in;
      tbl.push_back(v);
   endtask

   // model state
   typedef struct {
      logic [31:0] pc;
      logic [31:0] w;
   } held_t;

   held_t       hq[$];
   logic [31:0] m_pc;
   bit          m_out;
   bit          m_want;
   logic [31:0] m_fpc;
   bit          m_v;
   logic [31:0] m_ipc;
   logic [31:0] m_in;

   bit          mem_pend;
   int          mem_cnt;
   logic [31:0] mem_addr;
   bit          prev_rst;

   function automatic bit m_in_req();
      return !m_out && (hq.size() == 0);
   endfunction

   task automatic model_step();
      bit          redir;
      bit          ld;
      logic [31:0] tgt;
      logic [31:0] ld_pc;
      logic [31:0] ld_w;
      bit          acc;
      held_t       h;
      redir = (mux_to_pc == 2'd1) || (mux_to_pc == 2'd2);
      tgt   = ((mux_to_pc == 2'd1) ? branch_target : jalr_target)
              & 32'hFFFF_FFFC;
      ld    = 0;
      ld_pc = '0;
      ld_w  = '0;
      if (reset) begin
         m_pc  = 32'h0;
         m_out = 0;
         hq.delete();
         m_v   = 0;
         m_ipc = 32'h0;
         m_in  = NOP;
         return;
      end
      if (hq.size() != 0) begin
         if (redir) begin
            hq.delete();
            m_pc = tgt;
         end else if (!stall) begin
            h = hq.pop_front();
            ld = 1; ld_pc = h.pc; ld_w = h.w;
         end
      end else if (!m_out) begin
         acc = imem_req_ready;
         if (acc) begin
            mem_pend = 1;
            mem_cnt  = int'($urandom_range(1, 3));
            mem_addr = m_pc;
            m_out    = 1;
            m_want   = !redir;
            m_fpc    = m_pc;
         end
         if (redir)
            m_pc = tgt;
      end else if (m_want) begin
         if (imem_resp_valid) begin
            m_out = 0;
            if (redir) begin
               m_pc = tgt;
            end else begin
               if (stall) begin
                  h.pc = m_fpc; h.w = imem_resp_data;
                  hq.push_back(h);
               end else begin
                  ld = 1; ld_pc = m_fpc; ld_w = imem_resp_data;
               end
               m_pc = m_pc + 32'd4;
            end
         end else if (redir) begin
            m_pc   = tgt;
            m_want = 0;
         end
      end else begin
         if (redir)
            m_pc = tgt;
         if (imem_resp_valid)
            m_out = 0;
      end
      if (IF_Flush) begin
         m_v = 0; m_in = NOP; m_ipc = 32'h0;
      end else if (stall) begin
      end else if (ld) begin
         m_v = 1; m_in = ld_w; m_ipc = ld_pc;
      end else begin
         m_v = 0; m_in = NOP;
      end
   endtask

   initial begin
      reset           = 1'b1;
      mux_to_pc       = 2'b00;
      IF_Flush        = 1'b0;
      stall           = 1'b0;
      branch_target   = '0;
      jalr_target     = '0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;

      //   rst mux fl st rdy rv rd bt jt | req addr v pc instr
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, NOP);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, NOP);
      add(0, 0, 0, 0, 0, 1, iw(32'h0), 0, 0,
          1, 32'h4, 1, 32'h0, iw(32'h0));
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h4, 0, 32'h0, NOP);
      add(0, 0, 0, 0, 0, 1, iw(32'h4), 0, 0,
          1, 32'h8, 1, 32'h4, iw(32'h4));
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h8, 0, 32'h4, NOP);
      add(0, 0, 0, 1, 0, 1, iw(32'h8), 0, 0,
          0, 32'hC, 0, 32'h4, NOP);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'hC, 0, 32'h4, NOP);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC, 1, 32'h8, iw(32'h8));
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hC, 0, 32'h8, NOP);
      add(0, 1, 0, 0, 0, 0, 0, 32'h101, 0,
          0, 32'h100, 0, 32'h8, NOP);
      add(0, 0, 0, 0, 0, 1, iw(32'hC), 0, 0,
          1, 32'h100, 0, 32'h8, NOP);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h100, 0, 32'h8, NOP);
      add(0, 0, 0, 0, 0, 1, iw(32'h100), 0, 0,
          1, 32'h104, 1, 32'h100, iw(32'h100));
      add(0, 2, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFF,
          1, 32'hFFFF_FFFC, 0, 32'h0, NOP);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, NOP);
      add(0, 0, 0, 0, 0, 1, iw(32'hFFFF_FFFC), 0, 0,
          1, 32'h0, 1, 32'hFFFF_FFFC, iw(32'hFFFF_FFFC));
      add(0, 0, 0, 0, 1, 0, 0, 0, 0,
          0, 32'h0, 0, 32'hFFFF_FFFC, NOP);
      add(0, 0, 0, 0, 0, 1, iw(32'h0), 0, 0,
          1, 32'h4, 1, 32'h0, iw(32'h0));
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h4, 0, 32'h0, NOP);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, NOP);
      add(0, 3, 0, 0, 0, 1, iw(32'h4), 0, 32'h40,
          1, 32'h0, 0, 32'h0, NOP);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, NOP);
      add(0, 0, 0, 0, 0, 1, iw(32'h0), 0, 0,
          1, 32'h4, 1, 32'h0, iw(32'h0));
      add(0, 1, 0, 0, 1, 0, 0, 32'h20, 0, 0, 32'h20, 0, 32'h0, NOP);
      add(0, 0, 0, 0, 0, 1, iw(32'h4), 0, 0,
          1, 32'h20, 0, 32'h0, NOP);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h20, 0, 32'h0, NOP);
      add(0, 0, 0, 0, 0, 1, iw(32'h20), 0, 0,
          1, 32'h24, 1, 32'h20, iw(32'h20));
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h24, 0, 32'h20, NOP);
      add(0, 1, 0, 0, 0, 1, iw(32'h24), 32'h80, 0,
          1, 32'h80, 0, 32'h20, NOP);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         reset           = tbl[i].rst;
         mux_to_pc       = tbl[i].mux;
         IF_Flush        = tbl[i].fl;
         stall           = tbl[i].st;
         imem_req_ready  = tbl[i].rdy;
         imem_resp_valid = tbl[i].rv;
         imem_resp_data  = tbl[i].rd;
         branch_target   = tbl[i].bt;
         jalr_target     = tbl[i].jt;
         @(posedge clk);
         #1;
         check($sformatf("row%0d req_valid", i),
               {31'b0, imem_req_valid}, {31'b0, tbl[i].e_req});
         check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
         check($sformatf("row%0d if_valid", i),
               {31'b0, IF_ID_valid}, {31'b0, tbl[i].e_v});
         check($sformatf("row%0d if_pc", i), IF_ID_pc, tbl[i].e_pc);
         check($sformatf("row%0d if_instr", i), IF_ID_instr, tbl[i].e_in);
      end

      // randomized phase against the model
      mem_pend = 0;
      mem_cnt  = 0;
      mem_addr = '0;
      prev_rst = 0;
      m_pc = 32'h0; m_out = 0; m_want = 0; m_fpc = 32'h0;
      m_v = 0; m_ipc = 32'h0; m_in = NOP;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r;
         bit rst_now;
         @(negedge clk);
         if (cyc > 0) begin
            check($sformatf("rnd%0d req_valid", cyc),
                  {31'b0, imem_req_valid},
                  {31'b0, m_in_req() && !reset});
            check($sformatf("rnd%0d imem_addr", cyc), imem_addr, m_pc);
            check($sformatf("rnd%0d if_valid", cyc),
                  {31'b0, IF_ID_valid}, {31'b0, m_v});
            check($sformatf("rnd%0d if_pc", cyc), IF_ID_pc, m_ipc);
            check($sformatf("rnd%0d if_instr", cyc), IF_ID_instr, m_in);
         end
         rst_now = (cyc == 0) || ($urandom_range(0, 99) == 0);
         r = int'($urandom_range(0, 99));
         mux_to_pc     = (r < 8) ? 2'd1 : (r < 14) ? 2'd2 :
                         (r < 18) ? 2'd3 : 2'd0;
         branch_target = $urandom;
         jalr_target   = $urandom;
         IF_Flush      = ($urandom_range(0, 9) == 0);
         stall         = ($urandom_range(0, 3) == 0);
         imem_req_ready  = ($urandom_range(0, 2) != 0);
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
         if (mem_pend && !rst_now) begin
            mem_cnt--;
            // a reply still in flight across reset lands right after it
            if (mem_cnt <= 0 || prev_rst) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = iw(mem_addr);
               mem_pend        = 0;
            end
         end else if (!mem_pend && !rst_now && m_in_req()
                      && $urandom_range(0, 9) == 0) begin
            imem_resp_valid = 1'b1;
         end
         reset    = rst_now;
         prev_rst = rst_now;
         model_step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
